// File: rtl/cart_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cart_bus_pkg
// Brief   : Shared constants, state encoding and address helper for the
//           Bandai 2003 cartridge boot master.
// Rev     : 1.0
// ============================================================================
package cart_bus_pkg;

    localparam logic [7:0] KEY_ACK   = 8'h5A;
    localparam logic [7:0] KEY_NAK   = 8'hA5;
    localparam logic [7:0] ADDR_IDLE = 8'hFF;
    localparam logic [7:0] REG_BASE  = 8'hC0;

    localparam int                   BOOT_BITS    = 18;
    localparam logic [BOOT_BITS-1:0] BOOT_PATTERN = 18'h05140;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CRST   = 4'd1,
        S_KEY1   = 4'd2,
        S_KEY2   = 4'd3,
        S_SHIFT  = 4'd4,
        S_CHECK  = 4'd5,
        S_READY  = 4'd6,
        S_SETUP  = 4'd7,
        S_STROBE = 4'd8,
        S_HOLD   = 4'd9,
        S_FAIL   = 4'd10
    } cart_state_t;

    function automatic logic [7:0] reg_addr(input logic [1:0] idx);
        return REG_BASE | {6'b0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cart_serial_capture.sv
`default_nettype none
// ============================================================================
// Module  : cart_serial_capture
// Brief   : LSB-first deserializer for the mapper acknowledge stream.
// Rev     : 1.0
// ============================================================================
module cart_serial_capture
    import cart_bus_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic                 i_si,
    output logic [BOOT_BITS-1:0] o_cap,
    output logic                 o_done
);

    localparam int c_cnt_w = $clog2(BOOT_BITS + 1);

    logic [BOOT_BITS-1:0] r_cap;
    logic [c_cnt_w-1:0]   r_cnt;

    // Right shift so the first sample ends up in bit 0 after the last one.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cap <= '0;
            r_cnt <= '0;
        end else if (i_en) begin
            r_cap <= {i_si, r_cap[BOOT_BITS-1:1]};
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // High during the cycle whose closing edge takes the final sample.
    assign o_done = i_en && (r_cnt == c_cnt_w'(BOOT_BITS - 1));
    assign o_cap  = r_cap;

endmodule
`default_nettype wire

// File: rtl/cart_boot_master.sv
`default_nettype none
// ============================================================================
// Module  : cart_boot_master
// Brief   : Resets and unlocks a Bandai 2003 mapper, verifies its serial
//           acknowledge, then serves host accesses to the bank registers.
// Rev     : 1.0
// ============================================================================
module cart_boot_master
    import cart_bus_pkg::*;
#(
    parameter int CRST_CYCLES   = 4,
    parameter int STROBE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    output logic       boot_done,
    output logic       boot_fail,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [1:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       CART_RSTn,
    output logic       CEn,
    output logic       SSn,
    output logic       WEn,
    output logic       OEn,
    output logic [7:0] ADDR,
    output logic [7:0] DQ_O,
    output logic       DQ_OE,
    input  logic [7:0] DQ_I,
    input  logic       SI
);

    localparam int c_cnt_max = (CRST_CYCLES > STROBE_CYCLES) ? CRST_CYCLES : STROBE_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_crst_last = c_cnt_w'(CRST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_strb_last = c_cnt_w'(STROBE_CYCLES - 1);

    cart_state_t          r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_we;
    logic                 r_cart_rstn;
    logic                 r_ssn;
    logic                 r_wen;
    logic                 r_oen;
    logic                 r_dq_oe;
    logic [7:0]           r_addr;
    logic [7:0]           r_dq_o;
    logic [7:0]           r_rdata;
    logic                 r_boot_done;
    logic                 r_boot_fail;
    logic                 r_rsp_valid;
    logic [7:0]           r_rsp_rdata;
    logic [BOOT_BITS-1:0] w_cap;
    logic                 w_cap_done;
    logic                 w_req_ready;

    cart_serial_capture u_capture (
        .clk    (CLK),
        .rst    (RST),
        .i_clr  (r_state == S_CRST),
        .i_en   (r_state == S_SHIFT),
        .i_si   (SI),
        .o_cap  (w_cap),
        .o_done (w_cap_done)
    );

    // A reboot request always takes priority over a pending host access.
    assign w_req_ready = (r_state == S_READY) && !start;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_cart_rstn <= 1'b0;
            r_ssn       <= 1'b1;
            r_wen       <= 1'b1;
            r_oen       <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_addr      <= ADDR_IDLE;
            r_dq_o      <= 8'h00;
            r_rdata     <= 8'h00;
            r_boot_done <= 1'b0;
            r_boot_fail <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_READY, S_FAIL: begin
                    r_cart_rstn <= 1'b1;
                    if (start) begin
                        r_state     <= S_CRST;
                        r_cart_rstn <= 1'b0;
                        r_cnt       <= '0;
                        r_boot_done <= 1'b0;
                        r_boot_fail <= 1'b0;
                    end else if (w_req_ready && req_valid) begin
                        r_state <= S_SETUP;
                        r_we    <= req_we;
                        r_addr  <= reg_addr(req_reg);
                        r_dq_o  <= req_wdata;
                        r_dq_oe <= req_we;
                    end
                end
                S_CRST: begin
                    if (r_cnt == c_crst_last) begin
                        r_state     <= S_KEY1;
                        r_cart_rstn <= 1'b1;
                        r_addr      <= KEY_ACK;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_KEY1: begin
                    r_state <= S_KEY2;
                    r_addr  <= KEY_NAK;
                end
                S_KEY2: begin
                    r_state <= S_SHIFT;
                    r_addr  <= ADDR_IDLE;
                end
                S_SHIFT: begin
                    if (w_cap_done) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_cap == BOOT_PATTERN) begin
                        r_state     <= S_READY;
                        r_boot_done <= 1'b1;
                    end else begin
                        r_state     <= S_FAIL;
                        r_boot_fail <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_state <= S_STROBE;
                    r_cnt   <= '0;
                    r_ssn   <= 1'b0;
                    r_wen   <= ~r_we;
                    r_oen   <= r_we;
                end
                S_STROBE: begin
                    if (r_cnt == c_strb_last) begin
                        r_state <= S_HOLD;
                        r_ssn   <= 1'b1;
                        r_wen   <= 1'b1;
                        r_oen   <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= DQ_I;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_HOLD: begin
                    r_state     <= S_READY;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_we ? 8'h00 : r_rdata;
                    r_addr      <= ADDR_IDLE;
                    r_dq_o      <= 8'h00;
                    r_dq_oe     <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign boot_done = r_boot_done;
    assign boot_fail = r_boot_fail;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign CART_RSTn = r_cart_rstn;
    assign CEn       = 1'b1;
    assign SSn       = r_ssn;
    assign WEn       = r_wen;
    assign OEn       = r_oen;
    assign ADDR      = r_addr;
    assign DQ_O      = r_dq_o;
    assign DQ_OE     = r_dq_oe;

endmodule
`default_nettype wire
